fifo_umbral_param: RTL and testbench
====================================

# fifo_umbral_param

Parametrised synchronous FIFO with init-time programmable almost-full/almost-empty thresholds, a registered read port with a valid strobe, and overflow/underflow error detection. It is the generic buffer stage between the per-lane logic blocks of the transmission layer. It replaces the fixed-threshold per-lane FIFOs and can be instantiated at any width and depth.

## Interface
- DATA_WIDTH, 6, word width in bits
- ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH entries
- clk  in  1  single clock, all logic on posedge
- reset_L  in  1  asynchronous, active-low reset
- init  in  1  synchronous, active-low soft init; while 0, FIFO is cleared and thresholds are loaded
- wr_enable  in  1  write request
- rd_enable  in  1  read request
- data_in  in  DATA_WIDTH  write data
- umbral_alto  in  ADDR_WIDTH+1  almost-full threshold, sampled while init=0
- umbral_bajo  in  ADDR_WIDTH+1  almost-empty threshold, sampled while init=0
- data_out  out  DATA_WIDTH  registered read data
- valid_out  out  1  data_out holds a word popped in the previous cycle
- full, empty, almost_full, almost_empty  out  1  status flags
- overflow_err, underflow_err  out  1  error flags
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH

## Operation
- Asynchronous reset (reset_L=0) clears every output, pointer and count:
  - data_out=0, valid_out=0, count=0, errors=0.
  - Threshold registers take DEPTH-1 (alto) and 1 (bajo).
  - empty=1 and almost_empty=1; all other flags are 0.
- Init (init=0 at posedge, reset_L=1):
  - Same clearing as reset, except the threshold registers load umbral_alto and umbral_bajo.
  - Memory contents are not cleared.
  - wr_enable and rd_enable are ignored.
- Normal operation (reset_L=1, init=1):
  - Write accepted = wr_enable & (~full | read accepted).
  - Read accepted = rd_enable & ~empty.
  - An accepted write stores to mem[wr_ptr] and increments wr_ptr. An accepted read loads mem[rd_ptr] into data_out, sets valid_out=1 and increments rd_ptr.
  - Pointers wrap naturally modulo DEPTH.
  - With no accepted read, data_out=0 and valid_out=0.
  - count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Simultaneous events:
  - Full plus both requests: both are accepted, count stays DEPTH, no error.
  - Empty plus both requests: the write is accepted, the read is rejected, underflow_err is raised, count goes to 1.
- Errors:
  - wr_enable while full with no accepted read: the write is dropped and overflow_err is raised.
  - rd_enable while empty: underflow_err is raised.
- Flags (combinational from registered count and thresholds):
  - full = count==DEPTH.
  - empty = count==0.
  - almost_full = count>=alto_q.
  - almost_empty = count<=bajo_q.
  - If alto_q>DEPTH, almost_full is asserted only when full. If alto_q==0, almost_full is constantly 1.
- count never exceeds DEPTH and never underflows. Arithmetic is ADDR_WIDTH+1 bits wide.

## Timing
- Write-to-flag latency is 1 cycle: the first write into an empty FIFO deasserts empty on the next posedge.
- Read latency is 1 cycle: data_out and valid_out are valid in the cycle after the posedge at which rd_enable was sampled.
- Threshold changes take effect the cycle after init is sampled low.
- Error flags are asserted the cycle after the offending request (see Configuration for duration).
- reset_L asserted mid-operation clears outputs immediately, without waiting for clk. On reset_L release, the first posedge follows the init rules.

## Configuration
- FIFO_ERR_STICKY_EN
  - Defined: overflow_err and underflow_err are sticky. They hold 1 until reset_L=0 or init=0.
  - Undefined: each error is a single-cycle pulse, asserted for one cycle per offending request.

## Test plan
All scenarios use DATA_WIDTH=6, ADDR_WIDTH=3.
- Reset then init with umbral_alto=6, umbral_bajo=2 -> count=0, empty=1, almost_empty=1, almost_full=0, data_out=0.
- Write 0x01..0x08 -> full=1 after the 8th write. almost_full rises after the 6th write. A 9th write (0x3F) is dropped and overflow_err=1. Reads then return 0x01..0x08 in order, each one cycle after rd_enable with valid_out=1.
- With the FIFO full, assert wr_enable and rd_enable together for 4 cycles -> count stays 8, no error, and the output order is preserved across pointer wrap.
- From empty, assert wr_enable (0x2A) and rd_enable together -> underflow_err, valid_out=0, count=1. The next read returns 0x2A.
- Run 10 pushes/pops, then drop init for one cycle with umbral_alto=3 -> count=0, and almost_full now asserts at count=3. Assert reset_L=0 between clock edges -> all outputs clear without waiting for clk.
- Error-duration check, run twice:
  - With FIFO_ERR_STICKY_EN defined: a single overflow keeps overflow_err=1 until init=0.
  - With it undefined: overflow_err is high for exactly one cycle.

Source files
------------

// File: rtl/fifo_umbral_param.sv
// Synchronous FIFO with init-loaded almost-full/almost-empty thresholds, a registered read port and
// overflow/underflow flags. Define FIFO_ERR_STICKY_EN to make the error flags hold until reset/init.
module fifo_umbral_param #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  init,
  input  logic                  wr_enable,
  input  logic                  rd_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow_err,
  output logic                  underflow_err,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   ALTO_RST = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   BAJO_RST = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   alto_q, alto_d;
  logic [ADDR_WIDTH:0]   bajo_q, bajo_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic full_w, empty_w;
  logic rd_accept, wr_accept;
  logic ovf_set, unf_set;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // A read frees a slot in the same cycle, so a full FIFO can still take a write alongside it.
  assign rd_accept = init & rd_enable & ~empty_w;
  assign wr_accept = init & wr_enable & (~full_w | rd_accept);
  assign ovf_set   = wr_enable & full_w & ~rd_accept;
  assign unf_set   = rd_enable & empty_w;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    alto_d     = alto_q;
    bajo_d     = bajo_q;
    data_out_d = '0;
    valid_d    = 1'b0;
    ovf_d      = 1'b0;
    unf_d      = 1'b0;
    if (!init) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      alto_d   = umbral_alto;
      bajo_d   = umbral_bajo;
    end else begin
      if (rd_accept) begin
        data_out_d = mem[rd_ptr_q];
        valid_d    = 1'b1;
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
      end
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
`ifdef FIFO_ERR_STICKY_EN
      ovf_d = ovf_q | ovf_set;
      unf_d = unf_q | unf_set;
`else
      ovf_d = ovf_set;
      unf_d = unf_set;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      alto_q     <= ALTO_RST;
      bajo_q     <= BAJO_RST;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      alto_q     <= alto_d;
      bajo_q     <= bajo_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage is deliberately left out of reset and init so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  // The full term covers thresholds above DEPTH, which count alone could never reach.
  assign almost_full   = full_w | (count_q >= alto_q);
  assign almost_empty  = (count_q <= bajo_q);
  assign full          = full_w;
  assign empty         = empty_w;
  assign count         = count_q;
  assign data_out      = data_out_q;
  assign valid_out     = valid_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_fifo_umbral_param.sv
// Self-checking bench for fifo_umbral_param: vector table, directed corner sequences and random
// traffic against a queue-based model. Error-flag expectations follow FIFO_ERR_STICKY_EN.
module tb_fifo_umbral_param;

  localparam int DW    = 6;
  localparam int AW    = 3;
  localparam int DEPTH = 2**AW;
`ifdef FIFO_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_L;
  logic          init;
  logic          wr_enable;
  logic          rd_enable;
  logic [DW-1:0] data_in;
  logic [AW:0]   umbral_alto;
  logic [AW:0]   umbral_bajo;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          full, empty, almost_full, almost_empty;
  logic          overflow_err, underflow_err;
  logic [AW:0]   count;

  fifo_umbral_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .init         (init),
    .wr_enable    (wr_enable),
    .rd_enable    (rd_enable),
    .data_in      (data_in),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err),
    .count        (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model
  int mq[$];
  int m_alto, m_bajo, m_dout;
  bit m_valid, m_ov, m_un;

  typedef struct {
    bit          init_n;
    bit          wr;
    bit          rd;
    logic [5:0]  din;
    int          e_count;
    bit          e_full, e_empty, e_af, e_ae, e_ov, e_valid;
    int          e_dout;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_alto = DEPTH - 1;
    m_bajo = 1;
    m_dout = 0;
    m_valid = 0;
    m_ov = 0;
    m_un = 0;
  endtask

  task automatic model_update();
    int sz;
    bit rd_ok, wr_ok, ov, un;
    sz = mq.size();
    if (!init) begin
      mq.delete();
      m_alto = int'(umbral_alto);
      m_bajo = int'(umbral_bajo);
      m_dout = 0;
      m_valid = 0;
      m_ov = 0;
      m_un = 0;
    end else begin
      rd_ok = rd_enable && sz > 0;
      wr_ok = wr_enable && (sz < DEPTH || rd_ok);
      ov    = wr_enable && sz == DEPTH && !rd_ok;
      un    = rd_enable && sz == 0;
      if (rd_ok) begin
        m_dout  = mq.pop_front();
        m_valid = 1;
      end else begin
        m_dout  = 0;
        m_valid = 0;
      end
      if (wr_ok) mq.push_back(int'(data_in));
      m_ov = STICKY ? (m_ov | ov) : ov;
      m_un = STICKY ? (m_un | un) : un;
    end
  endtask

  task automatic check_model();
    int sz;
    sz = mq.size();
    chk("count",         32'(count),        32'(sz));
    chk("full",          32'(full),         32'(sz == DEPTH));
    chk("empty",         32'(empty),        32'(sz == 0));
    chk("almost_full",   32'(almost_full),  32'((sz >= m_alto) || (sz == DEPTH)));
    chk("almost_empty",  32'(almost_empty), 32'(sz <= m_bajo));
    chk("data_out",      32'(data_out),     32'(m_dout));
    chk("valid_out",     32'(valid_out),    32'(m_valid));
    chk("overflow_err",  32'(overflow_err), 32'(m_ov));
    chk("underflow_err", 32'(underflow_err),32'(m_un));
  endtask

  task automatic step(input bit i_n, input bit w, input bit r, input logic [5:0] d);
    init      = i_n;
    wr_enable = w;
    rd_enable = r;
    data_in   = d;
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  initial begin
    // Table: init (alto=6, bajo=2), 8 writes, dropped 9th write, 8 reads.
    tbl[0] = '{1'b0, 1'b0, 1'b0, 6'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{1'b1, 1'b1, 1'b0, 6'(i), i, (i == 8), 1'b0, (i >= 6), (i <= 2), 1'b0, 1'b0, 0};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 6'h3F, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    for (int k = 1; k <= 8; k++)
      tbl[9+k] = '{1'b1, 1'b0, 1'b1, 6'h00, 8-k, 1'b0, (k == 8), (8-k >= 6), (8-k <= 2),
                   STICKY, 1'b1, k};

    reset_L = 1'b0; init = 1'b1; wr_enable = 1'b0; rd_enable = 1'b0; data_in = '0;
    umbral_alto = 4'd6; umbral_bajo = 4'd2;
    model_reset();
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_almost_empty", 32'(almost_empty), 1);
    chk("rst_data_out", 32'(data_out), 0);
    @(negedge clk);
    reset_L = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].init_n, tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk($sformatf("tbl%0d_count", i), 32'(count),        32'(tbl[i].e_count));
      chk($sformatf("tbl%0d_full", i),  32'(full),         32'(tbl[i].e_full));
      chk($sformatf("tbl%0d_empty", i), 32'(empty),        32'(tbl[i].e_empty));
      chk($sformatf("tbl%0d_af", i),    32'(almost_full),  32'(tbl[i].e_af));
      chk($sformatf("tbl%0d_ae", i),    32'(almost_empty), 32'(tbl[i].e_ae));
      chk($sformatf("tbl%0d_ov", i),    32'(overflow_err), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_valid", i), 32'(valid_out),    32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_dout", i),  32'(data_out),     32'(tbl[i].e_dout));
    end

    // Full FIFO with simultaneous push/pop across the pointer wrap.
    for (int i = 0; i < 8; i++) step(1, 1, 0, 6'(8'h10 + i));
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 6'(8'h20 + i));
      chk("wrap_count", 32'(count), 8);
      chk("wrap_dout", 32'(data_out), 32'(8'h10 + i));
      chk("wrap_ov", 32'(overflow_err), 32'(STICKY));
    end
    for (int i = 0; i < 8; i++) step(1, 0, 1, 6'h00);

    // Empty with both requests: write goes in, read is rejected.
    step(0, 0, 0, 6'h00);
    step(1, 1, 1, 6'h2A);
    chk("emp_both_un", 32'(underflow_err), 1);
    chk("emp_both_valid", 32'(valid_out), 0);
    chk("emp_both_count", 32'(count), 1);
    step(1, 0, 1, 6'h00);
    chk("emp_both_dout", 32'(data_out), 32'h2A);
    chk("emp_both_un_after", 32'(underflow_err), 32'(STICKY));

    // Error duration after a single overflow.
    step(0, 0, 0, 6'h00);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 6'(i + 1));
    step(1, 1, 0, 6'h3F);
    chk("ovf_set", 32'(overflow_err), 1);
    step(1, 0, 0, 6'h00);
    chk("ovf_hold1", 32'(overflow_err), 32'(STICKY));
    step(1, 0, 0, 6'h00);
    chk("ovf_hold2", 32'(overflow_err), 32'(STICKY));
    step(0, 0, 0, 6'h00);
    chk("ovf_init_clr", 32'(overflow_err), 0);

    // Ten random pushes/pops, then re-init with alto=3.
    for (int i = 0; i < 10; i++) step(1, 1'($urandom), 1'($urandom), 6'($urandom));
    umbral_alto = 4'd3; umbral_bajo = 4'd1;
    step(0, 0, 0, 6'h00);
    chk("reinit_count", 32'(count), 0);
    step(1, 1, 0, 6'h05);
    step(1, 1, 0, 6'h06);
    chk("alto3_at2", 32'(almost_full), 0);
    step(1, 1, 0, 6'h07);
    chk("alto3_at3", 32'(almost_full), 1);

    // Random traffic with occasional re-init at arbitrary thresholds (0..15).
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        umbral_alto = 4'($urandom);
        umbral_bajo = 4'($urandom);
        step(0, 1'($urandom), 1'($urandom), 6'($urandom));
      end else begin
        step(1, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, 6'($urandom));
      end
    end

    // Asynchronous reset between clock edges.
    step(0, 0, 0, 6'h00);
    step(1, 1, 0, 6'h05);
    step(1, 1, 1, 6'h09);
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    chk("async_dout", 32'(data_out), 0);
    chk("async_valid", 32'(valid_out), 0);
    chk("async_count", 32'(count), 0);
    chk("async_empty", 32'(empty), 1);
    chk("async_ae", 32'(almost_empty), 1);
    chk("async_full", 32'(full), 0);
    chk("async_af", 32'(almost_full), 0);
    chk("async_ov", 32'(overflow_err), 0);
    chk("async_un", 32'(underflow_err), 0);
    umbral_alto = 4'd7; umbral_bajo = 4'd1;
    @(negedge clk);
    reset_L = 1'b1;
    step(1, 0, 0, 6'h00);
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 0, 6'(i));
      chk("dflt_alto_af", 32'(almost_full), 32'(i == 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
